// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer with single-outstanding imem handshake and redirect squash
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] pending_target, pending_n;
    logic        discard, discard_n;
    logic        if_valid_n;
    logic [31:0] if_instr_n, if_pc_n;
    logic [31:0] tgt;

    assign tgt       = {redirect_target[31:2], 2'b00};
    assign imem_req  = (state == REQ);
    assign imem_addr = fetch_pc;

    // next-state: a redirect seen mid-request is parked until the ack so the address never moves
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        pending_n  = pending_target;
        discard_n  = discard;
        if_valid_n = if_valid;
        if_instr_n = if_instr;
        if_pc_n    = if_pc;
        case (state)
            IDLE: begin
                state_n    = REQ;
                fetch_pc_n = redirect ? tgt : fetch_pc;
            end
            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        fetch_pc_n = tgt;
                        discard_n  = 1'b0;
                    end else if (discard) begin
                        fetch_pc_n = pending_target;
                        discard_n  = 1'b0;
                    end else begin
                        if_instr_n = imem_rdata;
                        if_pc_n    = fetch_pc;
                        if_valid_n = 1'b1;
                        fetch_pc_n = fetch_pc + 32'd4;
                        state_n    = HOLD;
                    end
                end else if (redirect) begin
                    discard_n = 1'b1;
                    pending_n = tgt;
                end
            end
            HOLD: begin
                if (redirect) begin
                    if_valid_n = 1'b0;
                    fetch_pc_n = tgt;
                    state_n    = REQ;
                end else if (id_ready) begin
                    if_valid_n = 1'b0;
                    state_n    = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state and output registers; reset abandons any outstanding fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            fetch_pc       <= RESET_PC;
            pending_target <= 32'h0;
            discard        <= 1'b0;
            if_valid       <= 1'b0;
            if_instr       <= 32'h0;
            if_pc          <= 32'h0;
        end else begin
            state          <= state_n;
            fetch_pc       <= fetch_pc_n;
            pending_target <= pending_n;
            discard        <= discard_n;
            if_valid       <= if_valid_n;
            if_instr       <= if_instr_n;
            if_pc          <= if_pc_n;
        end
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the MIPS core. It owns the fetch program counter and runs a single-outstanding req/ack handshake with instruction memory. It presents fetched instructions to decode through a valid/ready handshake. It applies branch/jump redirects from execute and discards any in-flight fetch that the redirect makes stale.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset (bits [1:0] must be 0)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-low (0 = reset asserted)
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address, word aligned
imem_ack  in  1  memory returns data this cycle; only meaningful while imem_req=1
imem_rdata  in  32  instruction word, valid when imem_ack=1
if_valid  out  1  if_instr/if_pc hold a valid instruction for decode
if_instr  out  32  fetched instruction
if_pc  out  32  address of if_instr
id_ready  in  1  decode accepts the instruction this cycle
redirect  in  1  branch taken or jump, one-cycle pulse from execute
redirect_target  in  32  new fetch address; bits [1:0] are forced to 0 internally

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, fetch_pc=RESET_PC, discard=0, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0. Reset mid-transaction abandons the fetch. An ack arriving while imem_req=0 is ignored.
- Registers: fetch_pc (32), discard (1), pending_target (32), state {IDLE, REQ, HOLD}. All outputs are registered or a pure decode of state; imem_addr = fetch_pc at all times.
- IDLE: imem_req=0. Unconditionally moves to REQ on the next edge. This gives one dead cycle after reset release.
- REQ: imem_req=1, and imem_addr stays stable until ack.
  - ack with discard=0 and redirect=0: capture if_instr<=imem_rdata, if_pc<=fetch_pc, if_valid<=1, fetch_pc<=fetch_pc+4. Go to HOLD. Ack in cycle N means if_valid=1 from cycle N+1.
  - ack with redirect=1 (any discard): drop the data, fetch_pc<=redirect_target&~3, discard<=0, stay in REQ. imem_req stays 1 with the new address next cycle.
  - ack with discard=1 and redirect=0: drop the data, fetch_pc<=pending_target, discard<=0, stay in REQ.
  - no ack, redirect=1: discard<=1, pending_target<=redirect_target&~3. The address must not change mid-request. A later redirect overwrites pending_target, so the last one wins.
- HOLD: imem_req=0, if_valid=1, and the outputs stay stable until consumed.
  - id_ready=1, redirect=0: if_valid<=0, go to REQ. The next fetch goes to fetch_pc, so throughput is 1 instruction per 2+memory-latency cycles.
  - redirect=1 (with or without id_ready): if_valid<=0, fetch_pc<=redirect_target&~3, go to REQ. The handshake counts as complete if id_ready=1, but the held instruction is treated as squashed by execute.
- Arithmetic: fetch_pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). There is no overflow flag.
- redirect in IDLE: fetch_pc<=redirect_target&~3, and the first fetch uses it.
- imem_rdata, and redirect_target when redirect=0, are don't-care and must not affect state.
- if_instr and if_pc hold their last values when if_valid=0.

Test Plan:
- Reset/boot: rst low then high, memory acks after 2 cycles with 0x2008_0005 -> imem_req rises 1 cycle after release with addr 0. if_valid=1 next cycle with if_instr=0x2008_0005, if_pc=0. With id_ready=1, the next request is at addr 4.
- Backpressure: hold id_ready=0 for 5 cycles in HOLD -> if_valid, if_instr and if_pc are stable. imem_req=0 throughout. The request for pc+4 issues only after id_ready.
- Redirect during pending fetch: req at 0x10, redirect to 0x43 (no ack), ack 2 cycles later -> data dropped, if_valid stays 0. The next request is at 0x40, and its ack yields if_pc=0x40.
- Redirect in HOLD / simultaneous with ack: redirect to 0x100 in the same cycle as the ack for 0x20 -> no valid instruction for 0x20, next addr 0x100. Redirect in HOLD also clears if_valid next cycle. Two redirects (0x200 then 0x300) during one pending fetch -> the next fetch is at 0x300.
- Wrap: redirect to 0xFFFF_FFFC, ack, id_ready -> next imem_addr=0x0000_0000.
- Async reset mid-request: drop rst between clock edges while imem_req=1 -> outputs go to reset values immediately. A later ack with imem_req=0 changes nothing, and the fetch restarts at RESET_PC.
